// File: rtl/imem_loader.sv
// imem_loader: word-array instruction memory with a byte-stream program loader that holds the core until loaded.
// Optional feature macro IMEM_CHECKSUM_EN adds a trailing XOR checksum byte and a terminal error state.
module imem_loader #(
   parameter int IMEM_DEPTH     = 256,
   parameter int IMEM_ADDR_WIDE = 8
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic [31:0] i_pc,
   output logic [31:0] o_inst,
   input  logic        i_ld_valid,
   input  logic [7:0]  i_ld_byte,
   output logic        o_ld_ready,
   output logic        o_cpu_hold,
   output logic        o_ld_done,
   output logic        o_ld_err,
   output logic [15:0] o_words_loaded
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
`ifdef IMEM_CHECKSUM_EN
      S_CHK,
      S_ERR,
`endif
      S_RUN
   } state_t;

   // State entered once the data words (or an empty header) are finished.
`ifdef IMEM_CHECKSUM_EN
   localparam state_t S_POST = S_CHK;
`else
   localparam state_t S_POST = S_RUN;
`endif

   localparam logic [16:0] DEPTH17 = 17'(IMEM_DEPTH);

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_cnt;
   logic [1:0]  r_byte_idx;
   logic [15:0] r_word_idx;
   logic [23:0] r_word_buf;
   logic        r_err;
   logic [15:0] r_words_loaded;
   logic [31:0] r_mem [IMEM_DEPTH];
`ifdef IMEM_CHECKSUM_EN
   logic [7:0]  r_xor;
`endif

   logic        w_xfer;
   logic        w_data_xfer;
   logic        w_word_end;
   logic        w_last_word;
   logic        w_in_range;
   logic [15:0] w_hdr_cnt;
   logic        w_unused_pc_bits;

   assign w_xfer      = i_ld_valid & o_ld_ready;
   assign w_data_xfer = w_xfer && (r_state == S_DATA);
   assign w_word_end  = w_data_xfer && (r_byte_idx == 2'd3);
   assign w_last_word = ({1'b0, r_word_idx} + 17'd1) == {1'b0, r_cnt};
   assign w_in_range  = {1'b0, r_word_idx} < DEPTH17;
   assign w_hdr_cnt   = {i_ld_byte, r_cnt[7:0]};

   always_ff @(posedge i_clk) begin
      if (!i_nrst) r_state <= S_HDR0;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      o_ld_ready   = 1'b1;
      o_cpu_hold   = 1'b1;
      o_ld_done    = 1'b0;
      case (r_state)
         S_HDR0: if (w_xfer) w_next_state = S_HDR1;
         S_HDR1: if (w_xfer) w_next_state = (w_hdr_cnt == 16'd0) ? S_POST : S_DATA;
         S_DATA: if (w_word_end && w_last_word) w_next_state = S_POST;
`ifdef IMEM_CHECKSUM_EN
         S_CHK:  if (w_xfer) w_next_state = (i_ld_byte == r_xor) ? S_RUN : S_ERR;
         S_ERR:  o_ld_ready = 1'b0;
`endif
         S_RUN: begin
            o_ld_ready = 1'b0;
            o_cpu_hold = 1'b0;
            o_ld_done  = 1'b1;
         end
         default: w_next_state = S_HDR0;
      endcase
   end

   // Overflowed words are consumed without a write; the error is flagged as DATA finishes.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_cnt          <= 16'd0;
         r_byte_idx     <= 2'd0;
         r_word_idx     <= 16'd0;
         r_word_buf     <= 24'd0;
         r_err          <= 1'b0;
         r_words_loaded <= 16'd0;
`ifdef IMEM_CHECKSUM_EN
         r_xor          <= 8'd0;
`endif
      end else begin
         if (w_xfer && r_state == S_HDR0) r_cnt[7:0]  <= i_ld_byte;
         if (w_xfer && r_state == S_HDR1) r_cnt[15:8] <= i_ld_byte;
         if (w_data_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_CHECKSUM_EN
            r_xor      <= r_xor ^ i_ld_byte;
`endif
            case (r_byte_idx)
               2'd0:    r_word_buf[7:0]   <= i_ld_byte;
               2'd1:    r_word_buf[15:8]  <= i_ld_byte;
               2'd2:    r_word_buf[23:16] <= i_ld_byte;
               default: r_word_idx        <= r_word_idx + 16'd1;
            endcase
            if (w_word_end && w_in_range && ({1'b0, r_words_loaded} < DEPTH17))
               r_words_loaded <= r_words_loaded + 16'd1;
            if (w_word_end && w_last_word && ({1'b0, r_cnt} > DEPTH17))
               r_err <= 1'b1;
         end
`ifdef IMEM_CHECKSUM_EN
         if (w_xfer && r_state == S_CHK && i_ld_byte != r_xor) r_err <= 1'b1;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_word_end && w_in_range)
         r_mem[r_word_idx[IMEM_ADDR_WIDE-1:0]] <= {i_ld_byte, r_word_buf};
   end

   // Byte offset within the word never affects the fetch.
   assign w_unused_pc_bits = ^i_pc[1:0];

   always_comb begin
      o_inst = 32'h0;
      if (!o_cpu_hold && (i_pc[31:IMEM_ADDR_WIDE+2] == '0))
         o_inst = r_mem[i_pc[IMEM_ADDR_WIDE+1:2]];
   end

   assign o_ld_err       = r_err;
   assign o_words_loaded = r_words_loaded;

endmodule
